// File: rtl/triangle_collector_pkg.sv
// ============================================================================
// Module   : triangle_collector_pkg
// Brief    : Shared grid-size default and collector FSM state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package triangle_collector_pkg;

    localparam int COORD_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } tc_state_t;

endpackage

`default_nettype wire

// File: rtl/tc_bitmap.sv
// ============================================================================
// Module   : tc_bitmap
// Brief    : Square pixel flop array with sync clear, one set port,
//            already-set flag and combinational row read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tc_bitmap
    import triangle_collector_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      set_en,
    input  logic [COORD_W-1:0]        set_x,
    input  logic [COORD_W-1:0]        set_y,
    output logic                      set_hit,
    input  logic [COORD_W-1:0]        rd_y,
    output logic [(1<<COORD_W)-1:0]   rd_row
);

    localparam int c_dim = 1 << COORD_W;

    logic [c_dim*c_dim-1:0] w_bits;
    logic [c_dim-1:0]       w_onehot;

    always_comb begin
        w_onehot        = '0;
        w_onehot[set_x] = 1'b1;
    end

    // Clear takes priority over the old contents but not over a same-cycle set.
    for (genvar gy = 0; gy < c_dim; gy++) begin : g_row
        logic             w_row_sel;
        logic [c_dim-1:0] r_row;

        assign w_row_sel = set_en && (set_y == COORD_W'(gy));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_row <= '0;
            end else if (clr || w_row_sel) begin
                r_row <= (clr ? '0 : r_row) | (w_row_sel ? w_onehot : '0);
            end
        end

        assign w_bits[gy*c_dim +: c_dim] = r_row;
    end

    assign set_hit = w_bits[{set_y, set_x}];
    assign rd_row  = w_bits[{rd_y, {COORD_W{1'b0}}} +: c_dim];

endmodule

`default_nettype wire

// File: rtl/triangle_collector.sv
// ============================================================================
// Module   : triangle_collector
// Brief    : Captures rasterizer pixel strobes into a bitmap and reports
//            distinct-pixel count, bounding box and protocol errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module triangle_collector
    import triangle_collector_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      busy,
    input  logic                      po,
    input  logic [COORD_W-1:0]        xo,
    input  logic [COORD_W-1:0]        yo,
    input  logic [COORD_W-1:0]        rd_y,
    output logic [(1<<COORD_W)-1:0]   rd_row,
    output logic                      done,
    output logic [2*COORD_W:0]        pix_cnt,
    output logic [COORD_W-1:0]        xmin,
    output logic [COORD_W-1:0]        xmax,
    output logic [COORD_W-1:0]        ymin,
    output logic [COORD_W-1:0]        ymax,
    output logic                      empty,
    output logic                      dup_err,
    output logic                      proto_err
);

    localparam int                 c_cnt_w = 2*COORD_W + 1;
    localparam logic [c_cnt_w-1:0] c_full  = {1'b1, {(2*COORD_W){1'b0}}};

    tc_state_t           r_state;
    logic                r_busy_q;
    logic [c_cnt_w-1:0]  r_pix_cnt;
    logic [COORD_W-1:0]  r_xmin, r_xmax, r_ymin, r_ymax;
    logic                r_done, r_empty, r_dup_err, r_proto_err;

    logic                w_rise, w_capture, w_hit, w_dup, w_first, w_new;
    logic [c_cnt_w-1:0]  w_cnt_base, w_cnt_next;

    // Edge detector resets high so a busy already asserted at reset release is not a rise.
    assign w_rise     = busy & ~r_busy_q;
    assign w_capture  = po & (w_rise | (r_state == ST_COLLECT));
    assign w_dup      = w_capture & w_hit & ~w_rise;
    assign w_cnt_base = w_rise ? '0 : r_pix_cnt;
    assign w_first    = (w_cnt_base == '0);
    assign w_new      = w_capture & ~w_dup & (w_cnt_base != c_full);
    assign w_cnt_next = w_cnt_base + {{(c_cnt_w-1){1'b0}}, w_new};

    tc_bitmap #(
        .COORD_W (COORD_W)
    ) u_bitmap (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_rise),
        .set_en  (w_capture),
        .set_x   (xo),
        .set_y   (yo),
        .set_hit (w_hit),
        .rd_y    (rd_y),
        .rd_row  (rd_row)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_busy_q    <= 1'b1;
            r_pix_cnt   <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_ymin      <= '0;
            r_ymax      <= '0;
            r_done      <= 1'b0;
            r_empty     <= 1'b0;
            r_dup_err   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_busy_q  <= busy;
            r_pix_cnt <= w_cnt_next;

            if (w_rise) begin
                r_xmin      <= '0;
                r_xmax      <= '0;
                r_ymin      <= '0;
                r_ymax      <= '0;
                r_dup_err   <= 1'b0;
                r_proto_err <= 1'b0;
            end

            if (w_capture) begin
                if (w_first) begin
                    r_xmin <= xo;
                    r_xmax <= xo;
                    r_ymin <= yo;
                    r_ymax <= yo;
                end else begin
                    if (xo < r_xmin) r_xmin <= xo;
                    if (xo > r_xmax) r_xmax <= xo;
                    if (yo < r_ymin) r_ymin <= yo;
                    if (yo > r_ymax) r_ymax <= yo;
                end
            end

            if (w_dup)
                r_dup_err <= 1'b1;
            if (po && !w_capture)
                r_proto_err <= 1'b1;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_rise) begin
                        r_state <= ST_COLLECT;
                        r_done  <= 1'b0;
                        r_empty <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (!busy) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_empty <= (w_cnt_next == '0);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_empty <= 1'b0;
                end
            endcase
        end
    end

    assign done      = r_done;
    assign pix_cnt   = r_pix_cnt;
    assign xmin      = r_xmin;
    assign xmax      = r_xmax;
    assign ymin      = r_ymin;
    assign ymax      = r_ymax;
    assign empty     = r_empty;
    assign dup_err   = r_dup_err;
    assign proto_err = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_triangle_collector.sv
// ============================================================================
// Module   : tb_triangle_collector
// Brief    : Directed self-checking bench for triangle_collector (COORD_W=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_triangle_collector;

    logic       clk;
    logic       reset;
    logic       busy;
    logic       po;
    logic [2:0] xo;
    logic [2:0] yo;
    logic [2:0] rd_y;
    logic [7:0] rd_row;
    logic       done;
    logic [6:0] pix_cnt;
    logic [2:0] xmin, xmax, ymin, ymax;
    logic       empty;
    logic       dup_err;
    logic       proto_err;

    int n_checks;
    int n_fail;

    triangle_collector #(
        .COORD_W (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .busy      (busy),
        .po        (po),
        .xo        (xo),
        .yo        (yo),
        .rd_y      (rd_y),
        .rd_row    (rd_row),
        .done      (done),
        .pix_cnt   (pix_cnt),
        .xmin      (xmin),
        .xmax      (xmax),
        .ymin      (ymin),
        .ymax      (ymax),
        .empty     (empty),
        .dup_err   (dup_err),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic b, input logic p, input logic [2:0] x, input logic [2:0] y);
        busy = b;
        po   = p;
        xo   = x;
        yo   = y;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bbox();
        return {20'd0, xmin, xmax, ymin, ymax};
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0; busy = 1'b0; po = 1'b0; xo = '0; yo = '0; rd_y = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pix_cnt", 32'(pix_cnt), 32'd0);
        check("rst_flags", {28'd0, done, empty, dup_err, proto_err}, 32'd0);
        check("rst_bbox", bbox(), 32'd0);
        check("rst_row0", 32'(rd_row), 32'd0);
        reset = 1'b1;
        cyc(0, 0, 0, 0);

        // Basic triangle
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 1);
        cyc(1, 1, 2, 1);
        cyc(1, 1, 1, 2);
        cyc(0, 0, 0, 0);
        rd_y = 3'd1; #1;
        check("t1_pix_cnt", 32'(pix_cnt), 32'd3);
        check("t1_bbox", bbox(), {20'd0, 3'd1, 3'd2, 3'd1, 3'd2});
        check("t1_row1", 32'(rd_row), 32'h06);
        rd_y = 3'd2; #1;
        check("t1_row2", 32'(rd_row), 32'h02);
        check("t1_flags", {28'd0, done, empty, dup_err, proto_err}, 32'b1000);
        cyc(0, 0, 0, 0);
        check("t1_hold_done", 32'(done), 32'd1);
        check("t1_hold_cnt", 32'(pix_cnt), 32'd3);

        // Duplicate pixel
        cyc(1, 0, 0, 0);
        rd_y = 3'd1; #1;
        check("t2_cleared_cnt", 32'(pix_cnt), 32'd0);
        check("t2_cleared_row", 32'(rd_row), 32'd0);
        check("t2_done_low", 32'(done), 32'd0);
        cyc(1, 1, 3, 4);
        cyc(1, 1, 3, 4);
        check("t2_dup_err", 32'(dup_err), 32'd1);
        check("t2_pix_cnt", 32'(pix_cnt), 32'd1);
        cyc(0, 0, 0, 0);
        rd_y = 3'd4; #1;
        check("t2_row4", 32'(rd_row), 32'h08);
        check("t2_bbox", bbox(), {20'd0, 3'd3, 3'd3, 3'd4, 3'd4});

        // po while IDLE
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(0, 1, 5, 5);
        rd_y = 3'd5; #1;
        check("t3_proto_err", 32'(proto_err), 32'd1);
        check("t3_row5", 32'(rd_row), 32'd0);
        check("t3_pix_cnt", 32'(pix_cnt), 32'd0);
        check("t3_done", 32'(done), 32'd0);

        // Empty triangle
        cyc(1, 0, 0, 0);
        check("t4_proto_clr", 32'(proto_err), 32'd0);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("t4_done_empty", {30'd0, done, empty}, 32'b11);
        check("t4_bbox", bbox(), 32'd0);
        check("t4_pix_cnt", 32'(pix_cnt), 32'd0);

        // Pixel on busy rise and on busy fall
        cyc(1, 1, 2, 3);
        cyc(0, 1, 7, 0);
        check("t5_pix_cnt", 32'(pix_cnt), 32'd2);
        check("t5_bbox", bbox(), {20'd0, 3'd2, 3'd7, 3'd0, 3'd3});
        check("t5_done_empty", {30'd0, done, empty}, 32'b10);
        rd_y = 3'd0; #1;
        check("t5_row0", 32'(rd_row), 32'h80);
        rd_y = 3'd3; #1;
        check("t5_row3", 32'(rd_row), 32'h04);
        cyc(0, 1, 1, 1);
        rd_y = 3'd1; #1;
        check("t5_done_proto", 32'(proto_err), 32'd1);
        check("t5_done_cnt", 32'(pix_cnt), 32'd2);
        check("t5_done_row1", 32'(rd_row), 32'd0);

        // Reset mid-collect
        cyc(1, 0, 0, 0);
        cyc(1, 1, 4, 4);
        cyc(1, 1, 5, 6);
        check("t6_pre_cnt", 32'(pix_cnt), 32'd2);
        reset = 1'b0;
        #1;
        rd_y = 3'd4; #1;
        check("t6_async_cnt", 32'(pix_cnt), 32'd0);
        check("t6_async_bbox", bbox(), 32'd0);
        check("t6_async_row4", 32'(rd_row), 32'd0);
        check("t6_async_flags", {28'd0, done, empty, dup_err, proto_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        check("t6_no_collect_proto", 32'(proto_err), 32'd1);
        check("t6_no_collect_cnt", 32'(pix_cnt), 32'd0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 6, 6);
        cyc(0, 0, 0, 0);
        check("t6_next_cnt", 32'(pix_cnt), 32'd1);
        check("t6_next_bbox", bbox(), {20'd0, 3'd6, 3'd6, 3'd6, 3'd6});
        check("t6_next_flags", {28'd0, done, empty, dup_err, proto_err}, 32'b1000);

        // Full grid then one more duplicate
        cyc(1, 0, 0, 0);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                cyc(1, 1, 3'(x), 3'(y));
        check("t7_full_cnt", 32'(pix_cnt), 32'd64);
        check("t7_full_dup", 32'(dup_err), 32'd0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        rd_y = 3'd7; #1;
        check("t7_sat_cnt", 32'(pix_cnt), 32'd64);
        check("t7_sat_dup", 32'(dup_err), 32'd1);
        check("t7_row7", 32'(rd_row), 32'hff);
        check("t7_bbox", bbox(), {20'd0, 3'd0, 3'd7, 3'd0, 3'd7});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/triangle_collector.md
TRIANGLE_COLLECTOR -- requirements
Module: triangle_collector

Interface
REQ-001 SHALL have parameter COORD_W, default 3, coordinate width; the grid is 2^COORD_W x 2^COORD_W pixels.
REQ-002 SHALL have port clk  input  1  sole clock; all flops on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port busy  input  1  rasterizer busy, sampled each clk.
REQ-005 SHALL have port po  input  1  pixel-valid strobe, one pixel per cycle when high.
REQ-006 SHALL have port xo  input  COORD_W  pixel x coordinate, valid when po=1.
REQ-007 SHALL have port yo  input  COORD_W  pixel y coordinate, valid when po=1.
REQ-008 SHALL have port rd_y  input  COORD_W  bitmap row select.
REQ-009 SHALL have port rd_row  output  2^COORD_W  bitmap row rd_y, combinational; bit i = pixel (x=i, y=rd_y).
REQ-010 SHALL have port done  output  1  high while in DONE.
REQ-011 SHALL have port pix_cnt  output  2*COORD_W+1  count of distinct pixels captured.
REQ-012 SHALL have ports xmin, xmax, ymin, ymax  output  COORD_W each  bounding box of captured pixels.
REQ-013 SHALL have port empty  output  1  high in DONE when pix_cnt=0.
REQ-014 SHALL have port dup_err  output  1  sticky; a pixel was received twice in one triangle.
REQ-015 SHALL have port proto_err  output  1  sticky; po was seen outside a collect window.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT and DONE.
REQ-017 SHALL transition IDLE->COLLECT or DONE->COLLECT on a busy 0->1 edge. The cycle of that edge SHALL clear the bitmap, pix_cnt, the bbox, dup_err and proto_err.
REQ-018 In COLLECT, po=1 SHALL set bitmap[yo][xo] one cycle later (registered, latency 1).
REQ-019 If the target bit is already set, pix_cnt SHALL NOT increment and dup_err SHALL be set. Otherwise pix_cnt SHALL increment by 1.
REQ-020 The first pixel SHALL load xmin=xmax=xo and ymin=ymax=yo. Later pixels SHALL update min/max unsigned, and duplicates SHALL also update them (no change in effect).
REQ-021 A po sampled in the same cycle as busy falls 1->0 in COLLECT SHALL be captured; the FSM SHALL then enter DONE.
REQ-022 A po sampled in the same cycle as the busy rising edge SHALL be captured into the freshly cleared bitmap, with the clear applied first.
REQ-023 po=1 in IDLE or DONE with no busy rise SHALL be ignored and SHALL set proto_err.
REQ-024 If busy falls with pix_cnt=0, the FSM SHALL enter DONE with empty=1 and all bbox fields =0.
REQ-025 pix_cnt SHALL saturate at 2^(2*COORD_W) and cannot wrap; this is reached only with a full grid.
REQ-026 done SHALL stay high in DONE until the next busy rise; the results and bitmap SHALL hold in DONE.
REQ-027 rd_row SHALL be readable in every state and SHALL reflect the writes of prior cycles.

Reset
REQ-028 reset low SHALL asynchronously force state IDLE, bitmap all 0, pix_cnt=0, bbox all 0, done=0, empty=0, dup_err=0, proto_err=0.
REQ-029 reset deasserted while busy=1 SHALL NOT enter COLLECT; the block SHALL wait for the next busy rise, and po seen meanwhile SHALL set proto_err.
REQ-030 A reset asserted mid-COLLECT SHALL discard the partial triangle.

Structure
REQ-031 A shared package SHALL hold the COORD_W default and the FSM state enum, for reuse by the rasterizer bench.
REQ-032 There SHALL be one sub-module, tc_bitmap: a 2^COORD_W x 2^COORD_W flop array with a sync clear, a single set port, a set-bit-already-set flag output and a combinational row read.

Verification
REQ-033 Busy rise; pixels (1,1),(2,1),(1,2); busy fall -> pix_cnt=3, bbox x 1..2, y 1..2, rd_y=1 gives rd_row=8'b0000_0110, done=1.
REQ-034 Pixel (3,4) sent twice in COLLECT -> pix_cnt=1, dup_err=1.
REQ-035 po=1 with (5,5) while IDLE -> proto_err=1, bitmap unchanged, pix_cnt=0.
REQ-036 Busy high 4 cycles with no po -> DONE, empty=1, bbox all 0.
REQ-037 Last pixel (7,0) sent in the busy-fall cycle -> captured, pix_cnt includes it, xmax=7.
REQ-038 Reset low mid-COLLECT after 2 pixels -> all outputs 0 immediately, state IDLE; next triangle counts from 0.
